// File: rtl/draw_sequencer.sv
// draw_sequencer: runs enabled drawing engines in ascending order and muxes the active one onto the VGA adapter
module draw_sequencer #(
  parameter int N_ENG = 4,
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int C_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [N_ENG-1:0]   eng_mask,
  output logic               busy,
  output logic               done,
  output logic [2:0]         active_idx,
  output logic [N_ENG-1:0]   eng_start,
  input  logic [N_ENG-1:0]   eng_done,
  input  logic [N_ENG*X_W-1:0] eng_x,
  input  logic [N_ENG*Y_W-1:0] eng_y,
  input  logic [N_ENG*C_W-1:0] eng_colour,
  input  logic [N_ENG-1:0]   eng_plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [C_W-1:0]     vga_colour,
  output logic               vga_plot
);
  typedef enum logic [1:0] {IDLE, RUN, RELEASE, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [N_ENG-1:0] mask_q, mask_d, start_q, start_d;
  logic done_q, done_d;
  logic [3:0] first, after;
  logic cur_done, cur_plot, run;
  logic [X_W-1:0] cur_x;
  logic [Y_W-1:0] cur_y;
  logic [C_W-1:0] cur_c;

  // lowest set bit of m at or above from; bit 3 of the result flags that one exists
  function automatic logic [3:0] next_set(input logic [N_ENG-1:0] m, input logic [3:0] from);
    next_set = '0;
    for (int i = N_ENG - 1; i >= 0; i--)
      if (m[i] && i >= int'(from)) next_set = {1'b1, 3'(i)};
  endfunction

  assign first = next_set(eng_mask, 4'd0);
  assign after = next_set(mask_q, {1'b0, idx_q} + 4'd1);
  assign run = state_q == RUN;

  // select the active engine's done flag and drawing signals
  always_comb begin
    cur_done = 1'b0;
    cur_plot = 1'b0;
    cur_x = '0;
    cur_y = '0;
    cur_c = '0;
    for (int i = 0; i < N_ENG; i++)
      if (i == int'(idx_q)) begin
        cur_done = eng_done[i];
        cur_plot = eng_plot[i];
        cur_x = eng_x[i*X_W +: X_W];
        cur_y = eng_y[i*Y_W +: Y_W];
        cur_c = eng_colour[i*C_W +: C_W];
      end
  end

  // sequencing decisions; abort beats everything once a sequence has begun
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    mask_d = mask_q;
    start_d = start_q;
    done_d = done_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      idx_d = '0;
      start_d = '0;
      done_d = 1'b0;
    end else
      case (state_q)
        IDLE: if (start && !abort) begin
          mask_d = eng_mask;
          state_d = first[3] ? RUN : DONE;
          idx_d = first[3] ? first[2:0] : 3'd0;
          start_d = first[3] ? N_ENG'(1) << first[2:0] : '0;
          done_d = !first[3];
        end
        RUN: if (cur_done) begin
          state_d = RELEASE;
          start_d = '0;
        end
        RELEASE: if (!cur_done) begin
          state_d = after[3] ? RUN : DONE;
          idx_d = after[3] ? after[2:0] : 3'd0;
          start_d = after[3] ? N_ENG'(1) << after[2:0] : '0;
          done_d = !after[3];
        end
        DONE: if (!start) begin
          state_d = IDLE;
          done_d = 1'b0;
        end
      endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      mask_q <= '0;
      start_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
      start_q <= start_d;
      done_q <= done_d;
    end

  assign busy = state_q == RUN || state_q == RELEASE;
  assign done = done_q;
  assign active_idx = idx_q;
  assign eng_start = start_q;
  assign vga_x = run ? cur_x : '0;
  assign vga_y = run ? cur_y : '0;
  assign vga_colour = run ? cur_c : '0;
  assign vga_plot = run & cur_plot;
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: table, hand-written and random checks of draw_sequencer against a queue-based model
module tb_draw_sequencer;
  localparam int N = 4, XW = 8, YW = 7, CW = 3;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic [N-1:0] eng_mask = '0, eng_start, eng_done = '0, eng_plot = '0;
  logic [N*XW-1:0] eng_x = '0;
  logic [N*YW-1:0] eng_y = '0;
  logic [N*CW-1:0] eng_colour = '0;
  logic busy, done, vga_plot;
  logic [2:0] active_idx;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  int pass_n = 0, tot_n = 0, aa_hits = 0;
  bit chk_en = 0, aa_mode = 0;
  int dur[N], hold[N], ph[N], cnt[N], hc[N];
  int started_q[$];

  draw_sequencer #(.N_ENG(N), .X_W(XW), .Y_W(YW), .C_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eng_mask(eng_mask),
    .busy(busy), .done(done), .active_idx(active_idx), .eng_start(eng_start),
    .eng_done(eng_done), .eng_x(eng_x), .eng_y(eng_y), .eng_colour(eng_colour),
    .eng_plot(eng_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // engines: start -> done after dur cycles, done held until start drops plus hold cycles
  initial forever begin
    tick;
    for (int e = 0; e < N; e++) begin
      eng_x[e*XW +: XW] = (aa_mode && e == 1) ? 8'hAA : 8'($urandom_range(0, 8'hA9));
      eng_y[e*YW +: YW] = 7'($urandom);
      eng_colour[e*CW +: CW] = 3'($urandom);
      eng_plot[e] = 1'($urandom);
      if (!rst_n) begin
        ph[e] = 0;
        eng_done[e] = 1'b0;
      end else
        case (ph[e])
          0: if (eng_start[e]) begin
            started_q.push_back(e);
            if (dur[e] == 0) begin eng_done[e] = 1'b1; ph[e] = 2; end
            else begin cnt[e] = dur[e]; ph[e] = 1; end
          end
          1: if (!eng_start[e]) ph[e] = 0;
             else begin
               cnt[e]--;
               if (cnt[e] == 0) begin eng_done[e] = 1'b1; ph[e] = 2; end
             end
          2: if (!eng_start[e]) begin
            if (hold[e] == 0) begin eng_done[e] = 1'b0; ph[e] = 0; end
            else begin hc[e] = hold[e]; ph[e] = 3; end
          end
          default: begin
            hc[e]--;
            if (hc[e] == 0) begin eng_done[e] = 1'b0; ph[e] = 0; end
          end
        endcase
    end
  end

  // reference: pending engines kept as a queue built from the mask at launch
  typedef enum int {M_IDLE, M_RUN, M_REL, M_DONE} ms_t;
  ms_t ms = M_IDLE;
  int cur = 0;
  int pend[$];
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || (ms != M_IDLE && abort)) begin
      ms = M_IDLE; cur = 0; pend.delete();
    end else
      case (ms)
        M_IDLE: if (start && !abort) begin
          pend.delete();
          for (int i = 0; i < N; i++) if (eng_mask[i]) pend.push_back(i);
          if (pend.size() > 0) begin cur = pend.pop_front(); ms = M_RUN; end
          else ms = M_DONE;
        end
        M_RUN: if (eng_done[cur]) ms = M_REL;
        M_REL: if (!eng_done[cur]) begin
          if (pend.size() > 0) begin cur = pend.pop_front(); ms = M_RUN; end
          else begin cur = 0; ms = M_DONE; end
        end
        M_DONE: if (!start) ms = M_IDLE;
      endcase
  end

  // every falling edge: all outputs against the reference
  initial forever begin
    logic [27:0] act, exp;
    bit r;
    @(negedge clk);
    if (chk_en) begin
      r = ms == M_RUN;
      act = {eng_start, busy, done, active_idx, vga_x, vga_y, vga_colour, vga_plot};
      exp = {r ? 4'(1 << cur) : 4'd0, r || ms == M_REL, ms == M_DONE, 3'(cur),
             r ? eng_x[cur*XW +: XW] : 8'd0, r ? eng_y[cur*YW +: YW] : 7'd0,
             r ? eng_colour[cur*CW +: CW] : 3'd0, r & eng_plot[cur]};
      if (vga_x == 8'hAA) aa_hits++;
      chk("cycle", act, exp);
    end
  end

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin tick; c++; end
    chk("done_reached", done, 1);
  endtask

  typedef struct {
    logic [3:0] mask;
    int d;
    int h;
    int n;
    logic [15:0] order;
  } vec_t;

  task automatic run_vec(input vec_t v);
    logic [15:0] got = '0;
    for (int e = 0; e < N; e++) begin dur[e] = v.d + e; hold[e] = v.h; end
    started_q.delete();
    eng_mask = v.mask;
    start = 1'b1;
    tick;
    tick;
    eng_mask = ~v.mask;
    wait_done(500);
    start = 1'b0;
    tick;
    tick;
    for (int k = 0; k < started_q.size() && k < 4; k++) got[k*4 +: 4] = 4'(started_q[k]);
    chk("vec_order", got, v.order);
    chk("vec_count", started_q.size(), v.n);
  endtask

  initial begin
    vec_t tv[7];
    int g, rel;
    tv[0] = '{4'b0101, 10, 0, 2, 16'h0020};
    tv[1] = '{4'b1111, 2, 1, 4, 16'h3210};
    tv[2] = '{4'b1000, 3, 2, 1, 16'h0003};
    tv[3] = '{4'b0110, 1, 0, 2, 16'h0021};
    tv[4] = '{4'b0001, 0, 3, 1, 16'h0000};
    tv[5] = '{4'b1010, 4, 1, 2, 16'h0031};
    tv[6] = '{4'b0000, 2, 0, 0, 16'h0000};
    for (int e = 0; e < N; e++) begin dur[e] = 1; hold[e] = 0; end
    #2 rst_n = 1'b0;
    #1 chk_en = 1;
    chk("reset", {eng_start, busy, done, active_idx, vga_plot, vga_x}, 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 7; i++) run_vec(tv[i]);

    // first start one cycle after start; done held while start high
    for (int e = 0; e < N; e++) begin dur[e] = 10; hold[e] = 0; end
    eng_mask = 4'b0101;
    start = 1'b1;
    chk("start_pre", eng_start, 0);
    tick;
    chk("start_lat", eng_start, 4'b0001);
    wait_done(500);
    repeat (3) tick;
    chk("done_held", done, 1);
    start = 1'b0;
    tick;
    chk("done_clear", done, 0);

    // engine 1 disabled but drawing 0xAA: never reaches the adapter
    aa_hits = 0;
    aa_mode = 1;
    start = 1'b1;
    wait_done(500);
    start = 1'b0;
    tick;
    aa_mode = 0;
    chk("plot_isolation", aa_hits, 0);

    // empty mask goes straight to done
    started_q.delete();
    eng_mask = 4'b0000;
    start = 1'b1;
    tick;
    chk("mask0_done", {busy, done}, 2'b01);
    start = 1'b0;
    tick;
    chk("mask0_nostart", started_q.size(), 0);

    // abort in IDLE blocks a start
    eng_mask = 4'b0101;
    start = 1'b1;
    abort = 1'b1;
    tick;
    chk("idle_abort", {eng_start, busy, done}, 0);
    abort = 1'b0;
    start = 1'b0;
    tick;

    // abort three cycles into engine 2
    for (int e = 0; e < N; e++) dur[e] = 20;
    start = 1'b1;
    g = 0;
    while (!eng_start[2] && g < 200) begin tick; g++; end
    chk("abort_reach2", eng_start, 4'b0100);
    repeat (3) tick;
    abort = 1'b1;
    tick;
    chk("abort_clear", {eng_start, busy, done}, 0);
    abort = 1'b0;
    start = 1'b0;
    tick;
    start = 1'b1;
    tick;
    chk("abort_restart", eng_start, 4'b0001);
    wait_done(500);
    start = 1'b0;
    tick;

    // asynchronous reset mid-run
    for (int e = 0; e < N; e++) dur[e] = 10;
    start = 1'b1;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {eng_start, busy, done, vga_plot}, 0);
    start = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    start = 1'b1;
    tick;
    chk("rst_restart", eng_start, 4'b0001);
    wait_done(500);
    start = 1'b0;
    tick;

    // engine 0 holds done 5 cycles after its start drops
    dur[0] = 3; hold[0] = 5; dur[1] = 3; hold[1] = 0;
    eng_mask = 4'b0011;
    start = 1'b1;
    g = 0;
    while (!eng_start[0] && g < 50) begin tick; g++; end
    chk("hold_start0", eng_start, 4'b0001);
    g = 0;
    while (eng_start[0] && g < 50) begin tick; g++; end
    chk("hold_drop", eng_start, 0);
    rel = 0;
    g = 0;
    while (!eng_start[1] && g < 50) begin
      if (busy && eng_start == 0) rel++;
      tick;
      g++;
    end
    chk("hold_release_len", rel, 6);
    chk("hold_done0_low", eng_done[0], 0);
    wait_done(500);
    start = 1'b0;
    tick;

    // random sequences, aborts and late mask changes
    for (int r = 0; r < 40; r++) begin
      for (int e = 0; e < N; e++) begin
        dur[e] = $urandom_range(0, 6);
        hold[e] = $urandom_range(0, 4);
      end
      eng_mask = 4'($urandom);
      start = 1'b1;
      abort = ($urandom_range(0, 9) == 0);
      tick;
      abort = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 15)) begin tick; eng_mask = 4'($urandom); end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        tick;
      end else begin
        wait_done(500);
        repeat ($urandom_range(0, 3)) tick;
        start = 1'b0;
        tick;
      end
    end
    tick;
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
